// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and bit-map helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  // Row 0 is driven low first after reset.
  localparam logic [KEY_ROWS-1:0] ROW_N_RST = 4'b1110;

  typedef enum logic [1:0] {
    WAIT_PRESS = 2'd0,
    PRESSED    = 2'd1,
    MULTI      = 2'd2
  } key_state_t;

  // Number of keys set in a map.
  function automatic logic [4:0] popcount16(input logic [KEY_NUM-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] first_set(input logic [KEY_NUM-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan4x4_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module col_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;

  // Resets to all-ones so an idle (released) keypad is seen during reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '1;
      o_q    <= '1;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: row drive, frame debounce, press FSM and hex digit accumulator.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [KEY_COLS-1:0] i_col_n,
  input  logic                i_entry_clr,
  output logic [KEY_ROWS-1:0] o_row_n,
  output logic                o_key_valid,
  output logic [3:0]          o_key_code,
  output logic                o_key_down,
  output logic                o_multi_key,
  output logic [KEY_NUM-1:0]  o_key_map,
  output logic [31:0]         o_key_entry
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_FRAMES - 1);

  logic [KEY_COLS-1:0] w_col_s;
  logic [CNT_W-1:0]    r_slot_cnt;
  logic [1:0]          r_row_idx;
  logic [KEY_NUM-1:0]  r_raw_frame;
  logic                r_frame_done;
  logic [KEY_NUM-1:0]  r_prev_frame;
  logic [DB_W-1:0]     r_stable_cnt;
  logic [DB_W-1:0]     w_stable_next;
  logic                w_frame_same;
  logic                r_map_upd;
  key_state_t          r_state;
  logic [4:0]          w_pop;

  col_sync #(.W(KEY_COLS)) u_col_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_col_n),
    .o_q   (w_col_s)
  );

  // Row slot timing: sample the columns on the last cycle of each slot, then move to the next row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_cnt   <= '0;
      r_row_idx    <= '0;
      o_row_n      <= ROW_N_RST;
      r_raw_frame  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_slot_cnt == SLOT_LAST) begin
        r_slot_cnt <= '0;
        r_raw_frame[r_row_idx*KEY_COLS +: KEY_COLS] <= ~w_col_s;
        r_row_idx  <= r_row_idx + 2'd1;
        o_row_n    <= {o_row_n[KEY_ROWS-2:0], o_row_n[KEY_ROWS-1]};
        if (r_row_idx == 2'(KEY_ROWS - 1)) r_frame_done <= 1'b1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

  // Stability count after this frame: saturating run length of identical frames.
  always_comb begin
    w_frame_same  = (r_raw_frame == r_prev_frame);
    w_stable_next = '0;
    if (w_frame_same) begin
      w_stable_next = (r_stable_cnt == DB_LAST) ? DB_LAST : r_stable_cnt + 1'b1;
    end
  end

  // Frame debounce: the map follows the raw frame once enough identical frames have been seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_frame <= '0;
      r_stable_cnt <= '0;
      o_key_map    <= '0;
      r_map_upd    <= 1'b0;
    end else begin
      r_map_upd <= 1'b0;
      if (r_frame_done) begin
        r_prev_frame <= r_raw_frame;
        r_stable_cnt <= w_stable_next;
        if (w_frame_same && (w_stable_next == DB_LAST) && (r_raw_frame != o_key_map)) begin
          o_key_map <= r_raw_frame;
          r_map_upd <= 1'b1;
        end
      end
    end
  end

  assign w_pop = popcount16(o_key_map);

  // Press FSM: one key_valid per clean single-key press, multi-key flagged until all released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= WAIT_PRESS;
      o_key_valid <= 1'b0;
      o_key_code  <= '0;
      o_key_down  <= 1'b0;
      o_multi_key <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (r_map_upd) begin
        case (r_state)
          WAIT_PRESS: begin
            if (w_pop == 5'd1) begin
              r_state     <= PRESSED;
              o_key_valid <= 1'b1;
              o_key_code  <= first_set(o_key_map);
              o_key_down  <= 1'b1;
            end else if (w_pop > 5'd1) begin
              r_state     <= MULTI;
              o_multi_key <= 1'b1;
            end
          end
          PRESSED: begin
            o_key_down <= 1'b0;
            if (o_key_map == '0) begin
              r_state <= WAIT_PRESS;
            end else begin
              r_state     <= MULTI;
              o_multi_key <= 1'b1;
            end
          end
          MULTI: begin
            if (o_key_map == '0) begin
              r_state     <= WAIT_PRESS;
              o_multi_key <= 1'b0;
            end
          end
          default: r_state <= WAIT_PRESS;
        endcase
      end
    end
  end

  // Digit accumulator: shift in each accepted code; a coincident clear keeps only that code.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_key_entry <= '0;
    end else if (o_key_valid && i_entry_clr) begin
      o_key_entry <= {28'h0, o_key_code};
    end else if (o_key_valid) begin
      o_key_entry <= {o_key_entry[27:0], o_key_code};
    end else if (i_entry_clr) begin
      o_key_entry <= '0;
    end
  end

endmodule
